// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle computer's fetch path.
//   state_t         : fetch sequencer control states
//   WORD_W          : datapath / address word width
//   IMEM_DEPTH      : instruction memory depth in words
//   HALT_INSTR_WORD : instruction encoding that stops the sequencer
package cpu_pkg;

    localparam int WORD_W     = 32;
    localparam int IMEM_DEPTH = 128;

    localparam logic [WORD_W-1:0] HALT_INSTR_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_unit.sv
// Program counter register for the fetch sequencer.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pc -> RESET_PC)
//   advance    : a committed cycle; pc moves to pc+1 or the redirect target
//   redirect   : take target instead of pc+1 when advancing
//   target     : redirect word address
//   restart    : force pc back to RESET_PC (leaving program-load mode)
//   pc         : current program counter
//   in_range   : pc addresses a valid instruction memory word
module pc_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = IMEM_DEPTH,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              redirect,
    input  logic [WORD_W-1:0] target,
    input  logic              restart,
    output logic [WORD_W-1:0] pc,
    output logic              in_range
);

    localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);

    logic [WORD_W-1:0] pc_reg;
    logic [WORD_W-1:0] pc_next;

    always_comb begin
        pc_next = pc_reg;
        if (restart) begin
            pc_next = RESET_PC;
        end else if (advance) begin
            // pc+1 wraps modulo 2^32; a wrapped or overrun pc is caught by
            // the range compare rather than here.
            pc_next = redirect ? target : pc_reg + WORD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc       = pc_reg;
    assign in_range = (pc_reg < DEPTH_W);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and sequences word-addressed fetch from the
// instruction memory, with run / halt / single-step control, branch
// redirect, datapath stall and a program-load mode for writing the memory
// while the core is halted.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   run_req, halt_req, step_req   : control pulses
//   load_req                      : level, holds the sequencer in LOAD
//   load_valid/addr/data          : program-load write port
//   load_ready                    : high while in LOAD
//   stall                         : datapath hold, freezes pc and state
//   branch_taken, branch_target   : next-pc redirect on a committed cycle
//   imem_addr/we/wdata/rdata      : instruction memory (combinational read)
//   instr, instr_valid            : instruction to the datapath + commit
//   pc, halted, fault             : status
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                DEPTH      = IMEM_DEPTH,
    parameter logic [WORD_W-1:0] RESET_PC   = '0,
    parameter logic [WORD_W-1:0] HALT_INSTR = HALT_INSTR_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              load_req,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    output logic              load_ready,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [WORD_W-1:0] imem_wdata,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic [WORD_W-1:0] pc,
    output logic              halted,
    output logic              fault
);

    localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);

    state_t state_reg;
    state_t state_next;

    logic pc_in_range;
    logic fetching;
    logic is_halt_instr;
    logic commit;
    logic restart_pc;

    pc_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk      (clk),
        .reset    (reset),
        .advance  (commit),
        .redirect (branch_taken),
        .target   (branch_target),
        .restart  (restart_pc),
        .pc       (pc),
        .in_range (pc_in_range)
    );

    assign fetching      = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign is_halt_instr = (imem_rdata == HALT_INSTR);
    assign commit        = fetching && !stall && pc_in_range && !is_halt_instr;
    assign restart_pc    = (state_reg == ST_LOAD) && !load_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_HALTED;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_HALTED: begin
                // halt_req outranks everything and simply keeps us halted.
                if (halt_req) begin
                    state_next = ST_HALTED;
                end else if (load_req) begin
                    state_next = ST_LOAD;
                end else if (step_req) begin
                    state_next = ST_STEP;
                end else if (run_req) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (!pc_in_range) begin
                        state_next = ST_FAULT;
                    end else if (is_halt_instr) begin
                        state_next = ST_HALTED;
                    end else if (halt_req) begin
                        // The instruction in this cycle still commits.
                        state_next = ST_HALTED;
                    end
                end
            end
            ST_STEP: begin
                if (!stall) begin
                    state_next = pc_in_range ? ST_HALTED : ST_FAULT;
                end
            end
            ST_LOAD: begin
                if (!load_req) begin
                    state_next = ST_HALTED;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_HALTED;
            end
        endcase
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops a pending load write in the same instant.
    assign load_ready  = (state_reg == ST_LOAD);
    assign imem_addr   = load_ready ? load_addr : pc;
    assign imem_we     = load_ready && load_valid && (load_addr < DEPTH_W);
    assign imem_wdata  = load_data;
    assign instr       = imem_rdata;
    assign instr_valid = commit;
    assign halted      = (state_reg == ST_HALTED) || (state_reg == ST_FAULT);
    assign fault       = (state_reg == ST_FAULT);

endmodule
